uart_tx_param: RTL and testbench

- Parametrised UART transmitter. It is the next generation of the team's fixed 8-bit transmitter FSM.
- Data width, stop-bit count and baud divisor are configurable. Input uses a valid/ready handshake, and every bit period is exact.
- Sits between a byte/word producer (CPU bridge or FIFO) and the board TX pin. Optional parity generation.

---
 rtl/uart_tx_param.sv | 150 +++++++++++++++
 tb/tb_uart_tx_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, exact DIV-clock bit periods, 1-2 stop bits.
// Define UART_TX_PARITY_EN to compile in a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DATA_BITS) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q;
  logic                   tx_q;
  logic                   done_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CW-1:0]          bit_q;
  logic [BW-1:0]          baud_q;
  logic [BW-1:0]          baud_d;
  logic                   bnd;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  // The wrap of the baud counter is the only place a line bit may change.
  always_comb begin
    bnd    = (baud_q == BAUD_LAST);
    baud_d = bnd ? '0 : baud_q + BW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) baud_q <= baud_d;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          if (bnd) begin
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bnd) begin
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + CW'(1);
              tx_q  <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bnd) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (bnd) begin
            if (bit_q == STOP_LAST) begin
              state_q <= S_IDLE;
              bit_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign done     = done_q;
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at DIV=10: 8N1, 7-bit/2-stop and odd-parity instances.
// Expected line patterns are listed LSB = first bit on the wire (start bit).
module tb_uart_tx_param;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_a = '0;
  logic [6:0] data_b = '0;
  logic [7:0] data_c = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  logic       tx_m, ready_m, busy_m, done_m;
  int         sel = 0;
  int         tests_run = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c),
    .tx(tx_c), .busy(busy_c), .done(done_c));

  always_comb begin
    tx_m = tx_a; ready_m = ready_a; busy_m = busy_a; done_m = done_a;
    case (sel)
      1: begin tx_m = tx_b; ready_m = ready_b; busy_m = busy_b; done_m = done_b; end
      2: begin tx_m = tx_c; ready_m = ready_c; busy_m = busy_c; done_m = done_c; end
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks a frame from the first sample after accept; records each bit's first sample and anomalies.
  task automatic capture(input int nbits, output logic [15:0] line, output int unstable,
                         output int ready_hi, output int done_hi, output int busy_lo);
    line = '0; unstable = 0; ready_hi = 0; done_hi = 0; busy_lo = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < DIV; c++) begin
        if (c == 0) line[b] = tx_m;
        else if (tx_m !== line[b]) unstable++;
        if (ready_m !== 1'b0) ready_hi++;
        if (done_m !== 1'b0) done_hi++;
        if (busy_m !== 1'b1) busy_lo++;
        tick;
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    sel = 0;
    data_a = 8'h00; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    repeat (3) tick;
    tests_run++; if (tx_m !== 1'b0) begin failed++; $display("FAIL rst_pre_start tx=%b want 0", tx_m); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (tx_m !== 1'b1) begin failed++; $display("FAIL rst_tx_async tx=%b want 1", tx_m); end
    tests_run++; if (busy_m !== 1'b0) begin failed++; $display("FAIL rst_busy busy=%b want 0", busy_m); end
    tests_run++; if (done_m !== 1'b0) begin failed++; $display("FAIL rst_done done=%b want 0", done_m); end
    tick; tick;
    rst = 1'b0;
    #1;
    tests_run++; if (ready_m !== 1'b1) begin failed++; $display("FAIL rst_ready_after ready=%b want 1", ready_m); end
    bad = 0;
    repeat (200) begin
      tick;
      if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
    end
    tests_run++; if (bad !== 0) begin failed++; $display("FAIL rst_idle_200 bad_cycles=%0d want 0", bad); end
  endtask

  task automatic test_frame_8n1;
    logic [15:0] line, exp;
    int unst, rhi, dhi, blo;
`ifdef UART_TX_PARITY_EN
    exp = 16'b0000_0101_0100_1010;  // 0,10100101 lsb-first,par 0,1
`else
    exp = 16'b0000_0011_0100_1010;  // 0,1,0,1,0,0,1,0,1,1
`endif
    sel = 0;
    data_a = 8'hA5; valid_a = 1'b1;
    tests_run++; if (ready_m !== 1'b1) begin failed++; $display("FAIL 8n1_ready_before ready=%b want 1", ready_m); end
    tick;
    valid_a = 1'b0; data_a = 8'h00;
    tests_run++; if (tx_m !== 1'b0) begin failed++; $display("FAIL 8n1_start_latency tx=%b want 0", tx_m); end
    capture(10 + P, line, unst, rhi, dhi, blo);
    tests_run++; if (line !== exp) begin failed++; $display("FAIL 8n1_line got=%b want=%b", line, exp); end
    tests_run++; if (unst !== 0) begin failed++; $display("FAIL 8n1_bit_width unstable=%0d want 0", unst); end
    tests_run++; if (rhi !== 0) begin failed++; $display("FAIL 8n1_ready_low ready_hi=%0d want 0", rhi); end
    tests_run++; if (dhi !== 0) begin failed++; $display("FAIL 8n1_done_early done_hi=%0d want 0", dhi); end
    tests_run++; if (blo !== 0) begin failed++; $display("FAIL 8n1_busy busy_lo=%0d want 0", blo); end
    tests_run++; if (done_m !== 1'b1) begin failed++; $display("FAIL 8n1_done_end done=%b want 1", done_m); end
    tests_run++; if (tx_m !== 1'b1) begin failed++; $display("FAIL 8n1_tx_idle tx=%b want 1", tx_m); end
    tick;
    tests_run++; if (done_m !== 1'b0) begin failed++; $display("FAIL 8n1_done_pulse done=%b want 0", done_m); end
    tests_run++; if (busy_m !== 1'b0) begin failed++; $display("FAIL 8n1_busy_end busy=%b want 0", busy_m); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] line, exp1, exp2;
    int unst, rhi, dhi, blo;
`ifdef UART_TX_PARITY_EN
    exp1 = 16'b0000_0100_0000_0000;
    exp2 = 16'b0000_0101_1111_1110;
`else
    exp1 = 16'b0000_0010_0000_0000;
    exp2 = 16'b0000_0011_1111_1110;
`endif
    sel = 0;
    data_a = 8'h00; valid_a = 1'b1;
    tick;
    data_a = 8'hFF;
    capture(10 + P, line, unst, rhi, dhi, blo);
    tests_run++; if (line !== exp1) begin failed++; $display("FAIL b2b_line1 got=%b want=%b", line, exp1); end
    tests_run++; if (rhi !== 0) begin failed++; $display("FAIL b2b_ready_low1 ready_hi=%0d want 0", rhi); end
    tests_run++; if (done_m !== 1'b1) begin failed++; $display("FAIL b2b_done1 done=%b want 1", done_m); end
    tests_run++; if (ready_m !== 1'b1) begin failed++; $display("FAIL b2b_ready_gap ready=%b want 1", ready_m); end
    tests_run++; if (tx_m !== 1'b1) begin failed++; $display("FAIL b2b_gap_high tx=%b want 1", tx_m); end
    tick;
    valid_a = 1'b0;
    tests_run++; if (ready_m !== 1'b0) begin failed++; $display("FAIL b2b_ready_one_cycle ready=%b want 0", ready_m); end
    tests_run++; if (tx_m !== 1'b0) begin failed++; $display("FAIL b2b_second_start tx=%b want 0", tx_m); end
    capture(10 + P, line, unst, rhi, dhi, blo);
    tests_run++; if (line !== exp2) begin failed++; $display("FAIL b2b_line2 got=%b want=%b", line, exp2); end
    tests_run++; if (unst !== 0) begin failed++; $display("FAIL b2b_bit_width unstable=%0d want 0", unst); end
    tests_run++; if (done_m !== 1'b1) begin failed++; $display("FAIL b2b_done2 done=%b want 1", done_m); end
    tick;
  endtask

  task automatic test_7bit_2stop;
    logic [15:0] line, exp;
    int unst, rhi, dhi, blo;
`ifdef UART_TX_PARITY_EN
    exp = 16'b0000_0110_1000_0010;  // 0,1000001 lsb-first,par 0,1,1
`else
    exp = 16'b0000_0011_1000_0010;  // 0,1,0,0,0,0,0,1,1,1
`endif
    sel = 1;
    data_b = 7'h41; valid_b = 1'b1;
    tick;
    valid_b = 1'b0;
    capture(10 + P, line, unst, rhi, dhi, blo);
    tests_run++; if (line !== exp) begin failed++; $display("FAIL 7b2s_line got=%b want=%b", line, exp); end
    tests_run++; if (unst !== 0) begin failed++; $display("FAIL 7b2s_bit_width unstable=%0d want 0", unst); end
    tests_run++; if (dhi !== 0) begin failed++; $display("FAIL 7b2s_done_early done_hi=%0d want 0", dhi); end
    tests_run++; if (done_m !== 1'b1) begin failed++; $display("FAIL 7b2s_done_end done=%b want 1", done_m); end
    tick;
    tests_run++; if (done_m !== 1'b0) begin failed++; $display("FAIL 7b2s_done_pulse done=%b want 0", done_m); end
    sel = 0;
  endtask

  task automatic test_parity;
    logic [15:0] line, exp;
    int unst, rhi, dhi, blo;
`ifdef UART_TX_PARITY_EN
    exp = 16'b0000_0111_0100_1010;  // odd parity of A5 is 1
`else
    exp = 16'b0000_0011_0100_1010;
`endif
    sel = 2;
    data_c = 8'hA5; valid_c = 1'b1;
    tick;
    valid_c = 1'b0;
    capture(10 + P, line, unst, rhi, dhi, blo);
    tests_run++; if (line !== exp) begin failed++; $display("FAIL parity_odd_line got=%b want=%b", line, exp); end
    tests_run++; if (unst !== 0) begin failed++; $display("FAIL parity_bit_width unstable=%0d want 0", unst); end
    tests_run++; if (done_m !== 1'b1) begin failed++; $display("FAIL parity_done_end done=%b want 1", done_m); end
    tick;
    sel = 0;
  endtask

  task automatic test_reset_midframe;
    logic [15:0] line, exp;
    int unst, rhi, dhi, blo, bad;
`ifdef UART_TX_PARITY_EN
    exp = 16'b0000_0100_0111_1000;
`else
    exp = 16'b0000_0010_0111_1000;  // 0,0,0,1,1,1,1,0,0,1
`endif
    sel = 0;
    data_a = 8'h3C; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    repeat (35) tick;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (tx_m !== 1'b1) begin failed++; $display("FAIL mid_rst_tx tx=%b want 1", tx_m); end
    tests_run++; if (busy_m !== 1'b0) begin failed++; $display("FAIL mid_rst_busy busy=%b want 0", busy_m); end
    bad = 0;
    repeat (3) begin
      tick;
      if (done_m !== 1'b0) bad++;
    end
    rst = 1'b0;
    repeat (120) begin
      tick;
      if (done_m !== 1'b0 || tx_m !== 1'b1) bad++;
    end
    tests_run++; if (bad !== 0) begin failed++; $display("FAIL mid_rst_no_done bad_cycles=%0d want 0", bad); end
    data_a = 8'h3C; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    capture(10 + P, line, unst, rhi, dhi, blo);
    tests_run++; if (line !== exp) begin failed++; $display("FAIL mid_rst_reframe got=%b want=%b", line, exp); end
    tests_run++; if (unst !== 0) begin failed++; $display("FAIL mid_rst_bit_width unstable=%0d want 0", unst); end
    tests_run++; if (done_m !== 1'b1) begin failed++; $display("FAIL mid_rst_done_end done=%b want 1", done_m); end
    tick;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    test_reset;
    test_frame_8n1;
    test_back_to_back;
    test_7bit_2stop;
    test_parity;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
